// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
//   div_op_e     - opcode encoding (bit0 = unsigned, bit1 = remainder)
//   div_state_e  - divider control states
//   UNSIGNED_BIT - opcode bit selecting unsigned operation
//   REM_BIT      - opcode bit selecting the remainder as the result
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned UNSIGNED_BIT = 0;
  localparam int unsigned REM_BIT      = 1;

endpackage

// File: rtl/div_iter.sv
// div_iter: multicycle radix-2 restoring divider for RV32M/RV64M DIV, DIVU, REM, REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in a single cycle.
//
// Ports:
//   clk        core clock
//   rst_b      synchronous active-low reset
//   in_valid   request valid            in_ready   divider idle and able to accept
//   opcode     bit0 unsigned, bit1 rem  op1/op2    dividend / divisor
//   flush      abort and drop any in-flight operation (highest priority)
//   out_valid  result valid             out_ready  consumer accepts the result
//   result     quotient or remainder as selected by opcode
//
// Optional feature (macro DIV_ITER_EARLY_OUT_EN): when |dividend| < |divisor| and the divisor is
// non-zero, the result (quotient 0, remainder op1) is produced in one cycle instead of XLEN+1.
// XLEN must be 32 or 64; CNTW is derived and must not be overridden.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      opcode,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] XlenOne = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MinVal  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNTW-1:0] LastCnt = CNTW'(XLEN - 1);

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return (~v) + XlenOne;
  endfunction

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;

  // Request decode, only meaningful while idle.
  logic            req_unsigned;
  logic            req_rem;
  logic            sign1, sign2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_by_zero;
  logic            overflow;

  always_comb begin
    req_unsigned = opcode[UNSIGNED_BIT];
    req_rem      = opcode[REM_BIT];
    sign1        = op1[XLEN-1] & ~req_unsigned;
    sign2        = op2[XLEN-1] & ~req_unsigned;
    // negate(MinVal) == MinVal, which is the correct unsigned magnitude.
    mag1         = sign1 ? negate(op1) : op1;
    mag2         = sign2 ? negate(op2) : op2;
    div_by_zero  = (op2 == '0);
    overflow     = ~req_unsigned & (op1 == MinVal) & (op2 == '1);
  end

  // One restoring step. rem_q never reaches the divisor, so its top bit is always zero and
  // the top bit of trial is a pure borrow.
  logic [XLEN+1:0] rem_shift;
  logic [XLEN+1:0] trial;
  logic            borrow;
  logic [XLEN:0]   rem_step;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    trial     = rem_shift - {2'b00, dvs_q};
    borrow    = trial[XLEN+1];
    rem_step  = borrow ? rem_shift[XLEN:0] : trial[XLEN:0];
    quo_step  = {quo_q[XLEN-2:0], ~borrow};
    // Sign flags are captured raw; unsigned ops never negate.
    quo_fix   = (neg_quo_q & ~op_q[UNSIGNED_BIT]) ? negate(quo_step) : quo_step;
    rem_fix   = (neg_rem_q & ~op_q[UNSIGNED_BIT]) ? negate(rem_step[XLEN-1:0])
                                                   : rem_step[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    if (flush) begin
      state_d  = IDLE;
      result_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d      = div_op_e'(opcode);
            neg_quo_d = op1[XLEN-1] ^ op2[XLEN-1];
            neg_rem_d = op1[XLEN-1];
            quo_d     = mag1;
            dvs_d     = mag2;
            rem_d     = '0;
            cnt_d     = '0;
            if (div_by_zero) begin
              state_d  = DONE;
              result_d = req_rem ? op1 : '1;
            end else if (overflow) begin
              state_d  = DONE;
              result_d = req_rem ? '0 : op1;
`ifdef DIV_ITER_EARLY_OUT_EN
            end else if (mag1 < mag2) begin
              state_d  = DONE;
              result_d = req_rem ? op1 : '0;
`endif
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == LastCnt) begin
            state_d  = DONE;
            result_d = op_q[REM_BIT] ? rem_fix : quo_fix;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter (XLEN = 32) against a plain-arithmetic
// reference model of the RISC-V divide semantics.
module tb_div_iter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      opcode = 2'b00;
  logic [XLEN-1:0] op1 = '0;
  logic [XLEN-1:0] op2 = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op1       (op1),
    .op2       (op2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension rules using native signed/unsigned division.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (op[0]) begin
      q = a / b;
      r = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint ma;
    longint mb;
    int sa;
    int sb;
    sa = a;
    sb = b;
    ma = op[0] ? longint'(a) : ((sa < 0) ? -longint'(sa) : longint'(sa));
    mb = op[0] ? longint'(b) : ((sb < 0) ? -longint'(sb) : longint'(sb));
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_ITER_EARLY_OUT_EN
    if (ma < mb) return 1;
`else
    if (ma < 0 || mb < 0) return 33;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Starts and ends just after a falling edge. hold = cycles out_ready stays low after out_valid.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input int hold);
    int lat;
    chk({tag, " in_ready before request"}, 64'(in_ready), 64'd1);
    opcode   = op;
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    opcode   = 2'($urandom);
    op1      = $urandom;
    op2      = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, 64'(result), 64'(exp_res));
    for (int i = 0; i < hold; i++) begin
      // Requests offered while a result is pending must be ignored.
      in_valid = 1'b1;
      op2      = 32'd0;
      @(negedge clk);
      chk({tag, " held out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " held result"}, 64'(result), 64'(exp_res));
      chk({tag, " held in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after accept"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready after accept"}, 64'(in_ready), 64'd1);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk({tag, " out_valid stays low"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset
    repeat (2) @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    rst_b = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op("DIV 20/-3", 2'b00, 32'h14, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, 0);
    run_op("REM 20/-3", 2'b10, 32'h14, 32'hFFFF_FFFD, 32'h0000_0002, 33, 0);
    run_op("DIVU ffffffff/2", 2'b01, 32'hFFFF_FFFF, 32'h2, 32'h7FFF_FFFF, 33, 0);
    run_op("REMU ffffffff/2", 2'b11, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 33, 0);
    run_op("DIV 7/0", 2'b00, 32'h7, 32'h0, 32'hFFFF_FFFF, 1, 0);
    run_op("REM 7/0", 2'b10, 32'h7, 32'h0, 32'h0000_0007, 1, 0);
    run_op("DIVU min/0", 2'b01, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 1, 0);
    run_op("DIV overflow", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("REM overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    run_op("DIV -7/2 backpressure", 2'b00, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, 5);

    // flush together with a request in IDLE: the request must not be taken
    in_valid = 1'b1;
    flush    = 1'b1;
    opcode   = 2'b00;
    op1      = 32'h5;
    op2      = 32'h0;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush+req in_ready", 64'(in_ready), 64'd1);
    watch_idle("flush+req", 3);

    // flush in CALC cycle 10
    opcode   = 2'b00;
    op1      = 32'd1000;
    op2      = 32'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush calc out_valid", 64'(out_valid), 64'd0);
    chk("flush calc in_ready", 64'(in_ready), 64'd1);
    watch_idle("flush calc", 40);
    run_op("DIVU 9/4 after flush", 2'b01, 32'd9, 32'd4, 32'd2, 33, 0);

    // reset in CALC
    opcode   = 2'b01;
    op1      = 32'hDEAD_BEEF;
    op2      = 32'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("reset calc out_valid", 64'(out_valid), 64'd0);
    chk("reset calc result", 64'(result), 64'd0);
    chk("reset calc in_ready", 64'(in_ready), 64'd1);
    rst_b = 1'b1;
    watch_idle("reset calc", 40);
    run_op("DIVU 9/4 after reset", 2'b01, 32'd9, 32'd4, 32'd2, 33, 0);

    // Randomized against the reference model
    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom);
      ra  = pick_operand();
      rb  = pick_operand();
      run_op($sformatf("rand%0d op%0d %h/%h", n, rop, ra, rb), rop, ra, rb,
             ref_result(rop, ra, rb), ref_latency(rop, ra, rb), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
